// File: rtl/ext_pipe.sv
// Pipelined immediate-extension unit: extends an IN_W-bit immediate to OUT_W bits
// and buffers up to two results behind a valid/ready handshake.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int EXT_W = OUT_W - IN_W;

    // Handshake: a beat moves on a rising edge only when valid && ready are both
    // high; valid never waits on ready, and ready/valid come from registered count.
    logic             sign_bit;
    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_val;

    logic [OUT_W-1:0] buf_data [2];
    logic [1:0]       buf_neg;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             accept;
    logic             deliver;

    always_comb begin
        sign_bit = in_data[IN_W-1];
        sign_ext = {{EXT_W{sign_bit}}, in_data};
        ext_val  = '0;
        case (in_mode)
            2'd0:    ext_val = {{EXT_W{1'b0}}, in_data};
            2'd1:    ext_val = sign_ext;
            2'd2:    ext_val = {in_data, {EXT_W{1'b0}}};
            default: ext_val = {sign_ext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign out_data  = buf_data[rd_ptr];
    assign out_neg   = buf_neg[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_neg     <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            xfer_cnt    <= '0;
        end else begin
            if (accept) begin
                buf_data[wr_ptr] <= ext_val;
                buf_neg[wr_ptr]  <= sign_bit;
                wr_ptr           <= ~wr_ptr;
            end
            if (deliver) begin
                rd_ptr   <= ~rd_ptr;
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            case ({accept, deliver})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: a 16->32 instance with a 4-bit transfer counter
// and an 8->32 instance for the narrow-immediate cases.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_neg;
    logic [3:0]  xfer_cnt;

    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [7:0]  in_data_b = '0;
    logic [1:0]  in_mode_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [31:0] out_data_b;
    logic        out_neg_b;
    logic [15:0] xfer_cnt_b;

    logic [32:0] exp_q[$];
    logic [32:0] exp_b_q[$];
    logic [32:0] e_mon;
    logic [32:0] e_mon_b;
    int          checks = 0;
    int          failures = 0;
    int          n_deliv = 0;

    ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_neg(out_neg), .xfer_cnt(xfer_cnt)
    );

    ext_pipe #(.IN_W(8), .OUT_W(32), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_mode(in_mode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_neg(out_neg_b), .xfer_cnt(xfer_cnt_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: call at posedge+1; holds the beat until accepted, then returns at posedge+1.
    task automatic send(input logic [15:0] d, input logic [1:0] m,
                        input logic [31:0] e, input logic ne);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_mode = m;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ne, e});
                break;
            end
            t++;
            if (t > 50) begin
                chk("send_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [1:0] m,
                          input logic [31:0] e, input logic ne);
        int t = 0;
        in_valid_b = 1'b1; in_data_b = d; in_mode_b = m;
        forever begin
            @(negedge clk);
            if (in_ready_b) begin
                exp_b_q.push_back({ne, e});
                break;
            end
            t++;
            if (t > 50) begin
                chk("send_b_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 || exp_b_q.size() != 0) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                chk("drain_timeout", 1, 0);
                exp_q.delete();
                exp_b_q.delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        exp_b_q.delete();
        n_deliv = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Monitors: evaluate at negedge whether the coming edge delivers, and check the head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {32'd0, out_data}, 64'hDEAD);
            end else begin
                e_mon = exp_q.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, e_mon[31:0]});
                chk("out_neg", {63'd0, out_neg}, {63'd0, e_mon[32]});
                n_deliv++;
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) begin
                chk("unexpected_beat_b", {32'd0, out_data_b}, 64'hDEAD);
            end else begin
                e_mon_b = exp_b_q.pop_front();
                chk("out_data_b", {32'd0, out_data_b}, {32'd0, e_mon_b[31:0]});
                chk("out_neg_b", {63'd0, out_neg_b}, {63'd0, e_mon_b[32]});
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_in_ready", {63'd0, in_ready}, 1);
        chk("rst_out_data", {32'd0, out_data}, 0);
        chk("rst_xfer_cnt", {60'd0, xfer_cnt}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode arithmetic, streaming with out_ready high
        out_ready = 1'b1;
        send(16'h8001, 2'd0, 32'h0000_8001, 1'b1);
        send(16'h8001, 2'd1, 32'hFFFF_8001, 1'b1);
        send(16'h1234, 2'd2, 32'h1234_0000, 1'b0);
        send(16'hFFFF, 2'd3, 32'hFFFF_FFFC, 1'b1);
        send(16'h0004, 2'd3, 32'h0000_0010, 1'b0);
        send(16'h7FFF, 2'd1, 32'h0000_7FFF, 1'b0);
        send(16'h8000, 2'd3, 32'hFFFE_0000, 1'b1);
        drain();
        chk("xfer_after_modes", {60'd0, xfer_cnt}, 64'd7);

        // Back-pressure: two beats absorbed, third held off
        do_reset();
        out_ready = 1'b0;
        send(16'h00A1, 2'd0, 32'h0000_00A1, 1'b0);
        send(16'h00B2, 2'd0, 32'h0000_00B2, 1'b0);
        chk("bp_in_ready_low", {63'd0, in_ready}, 0);
        chk("bp_out_valid", {63'd0, out_valid}, 1);
        fork
            send(16'h00C3, 2'd0, 32'h0000_00C3, 1'b0);
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("bp_head_stable", {32'd0, out_data}, 64'h0000_00A1);
        chk("bp_still_full", {63'd0, in_ready}, 0);
        out_ready = 1'b1;
        wait fork;
        drain();
        chk("bp_xfer_cnt", {60'd0, xfer_cnt}, 64'd3);

        // Count 1 with simultaneous accept and deliver
        do_reset();
        out_ready = 1'b0;
        send(16'h1111, 2'd0, 32'h0000_1111, 1'b0);
        out_ready = 1'b1;
        send(16'h2222, 2'd2, 32'h2222_0000, 1'b0);
        chk("sim_out_valid", {63'd0, out_valid}, 1);
        chk("sim_in_ready", {63'd0, in_ready}, 1);
        chk("sim_new_head", {32'd0, out_data}, 64'h2222_0000);
        drain();
        chk("sim_xfer_cnt", {60'd0, xfer_cnt}, 64'd2);

        // Asynchronous reset mid-stream with two beats buffered
        do_reset();
        out_ready = 1'b1;
        send(16'h0005, 2'd0, 32'h0000_0005, 1'b0);
        drain();
        out_ready = 1'b0;
        send(16'hAAAA, 2'd1, 32'hFFFF_AAAA, 1'b1);
        send(16'hBBBB, 2'd1, 32'hFFFF_BBBB, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 1);
        chk("mid_rst_out_data", {32'd0, out_data}, 0);
        chk("mid_rst_out_neg", {63'd0, out_neg}, 0);
        chk("mid_rst_xfer_cnt", {60'd0, xfer_cnt}, 0);
        exp_q.delete();
        n_deliv = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h0042, 2'd0, 32'h0000_0042, 1'b0);
        drain();
        chk("post_rst_xfer_cnt", {60'd0, xfer_cnt}, 64'd1);

        // Transfer counter wrap on the 4-bit counter
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(16'(i), 2'd0, 32'(i), 1'b0);
            @(posedge clk); #1;
            if (i == 15) chk("wrap_15", {60'd0, xfer_cnt}, 64'd15);
            if (i == 16) chk("wrap_16", {60'd0, xfer_cnt}, 64'd0);
            if (i == 17) chk("wrap_17", {60'd0, xfer_cnt}, 64'd1);
        end
        drain();
        chk("wrap_model", {60'd0, xfer_cnt}, 64'(n_deliv % 16));

        // Narrow immediate instance
        send_b(8'h80, 2'd1, 32'hFFFF_FF80, 1'b1);
        send_b(8'h7F, 2'd1, 32'h0000_007F, 1'b0);
        send_b(8'hAB, 2'd2, 32'hAB00_0000, 1'b1);
        send_b(8'hAB, 2'd0, 32'h0000_00AB, 1'b1);
        send_b(8'h81, 2'd3, 32'hFFFF_FE04, 1'b1);
        drain();
        chk("b_xfer_cnt", {48'd0, xfer_cnt_b}, 64'd5);

        chk("leftover_exp", 64'(exp_q.size() + exp_b_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
